// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter in front of a single-port synchronous 8K x 32 memory.
// Define ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0] state;
    logic       gnt_d;
    logic       pick_d;

    // gnt_d holds the owner of the current (or most recent) transaction
    always_comb begin
        pick_d = 1'b0;
`ifdef ARB_RR_EN
        pick_d = d_req && (!i_req || !gnt_d);
`else
        pick_d = d_req;
`endif
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_d    <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req || i_req) begin
                        gnt_d    <= pick_d;
                        mem_addr <= pick_d ? d_addr : i_addr;
                        mem_we   <= pick_d & d_we;
                        if (pick_d) mem_din <= d_wdata;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mem_we is only ever set for a granted store
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        d_ack <= 1'b1;
                        state <= ACK;
                    end else begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (gnt_d) d_rdata <= mem_dout;
                    else       i_rdata <= mem_dout;
                    d_ack <= gnt_d;
                    i_ack <= !gnt_d;
                    state <= ACK;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// synchronous memory model and a preload port into that model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [12:0] i_addr, d_addr;
    logic [31:0] d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ack, d_ack;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        busy;

    logic        pl_we;
    logic [12:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [0:8191];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // One transaction on a port (p=1 data, p=0 fetch), checks latency,
    // busy length, store pulse count and the resulting rdata.
    task automatic run(input bit p, input logic we, input logic [12:0] a,
                       input logic [31:0] wd, input int lat,
                       input logic [31:0] exp_rd, input string tag);
        int n, wec, bc;
        logic ackv;
        n = 0; wec = 0; bc = 0;
        if (p) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = a;
        end
        do begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (mem_we) begin
                wec++;
                chk({tag, "_waddr"}, 32'(mem_addr), 32'(a));
                chk({tag, "_wdin"}, mem_din, wd);
            end
            ackv = p ? d_ack : i_ack;
        end while (!ackv && n < 12);
        d_req = 1'b0; i_req = 1'b0;
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy"}, bc, lat);
        chk({tag, "_wepulses"}, wec, (p && we) ? 1 : 0);
        chk({tag, "_rdata"}, p ? d_rdata : i_rdata, exp_rd);
        @(negedge clk);
        chk({tag, "_ackdrop"}, {30'd0, i_ack, d_ack}, 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int k, n, di, ii;
        logic [31:0] exp_f [3];
        logic [12:0] fa [3];
        string seq, exp_seq;

        rst = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        chk("rst_outs", {29'd0, mem_we, i_ack, d_ack}, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_din", mem_din, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        chk("rst_busy", 32'(busy), 0);

        preload(13'h0010, 32'h11111111);
        preload(13'h0020, 32'h22222222);
        preload(13'h1FFE, 32'hAAAA1FFE);
        preload(13'h1FFF, 32'hBBBB1FFF);
        preload(13'h0000, 32'hCCCC0000);
        preload(13'h0100, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run(1, 1, 13'h0005, 32'hDEADBEEF, 2, 32'h0, "store5");
        chk("store5_mem", mem[5], 32'hDEADBEEF);
        run(1, 0, 13'h0005, 32'h0, 3, 32'hDEADBEEF, "load5");
        run(1, 1, 13'h0006, 32'h12345678, 2, 32'hDEADBEEF, "store6_hold");

        // simultaneous requests: data first, fetch waits for the data ack
        i_req = 1; i_addr = 13'h0010;
        d_req = 1; d_we = 0; d_addr = 13'h0020;
        di = 0; ii = 0;
        for (int c = 1; c <= 12 && ii == 0; c++) begin
            @(negedge clk);
            if (d_ack) begin
                di = c; d_req = 0;
                chk("both_drd", d_rdata, 32'h22222222);
            end
            if (i_ack) begin
                ii = c; i_req = 0;
                chk("both_ird", i_rdata, 32'h11111111);
                chk("both_dhold", d_rdata, 32'h22222222);
            end
        end
        i_req = 0; d_req = 0;
        chk("both_dcyc", di, 3);
        chk("both_icyc", ii, 7);
        @(negedge clk);

        // continuous fetch across the top of the address space
        fa[0] = 13'h1FFE; fa[1] = 13'h1FFF; fa[2] = 13'h0000;
        exp_f[0] = 32'hAAAA1FFE; exp_f[1] = 32'hBBBB1FFF; exp_f[2] = 32'hCCCC0000;
        k = 0;
        i_req = 1; i_addr = fa[0];
        for (int c = 1; c <= 20 && k < 3; c++) begin
            @(negedge clk);
            if (i_ack) begin
                chk($sformatf("wrap%0d_rd", k), i_rdata, exp_f[k]);
                chk($sformatf("wrap%0d_cyc", k), c, 3 + 4 * k);
                k++;
                if (k < 3) i_addr = fa[k];
                else i_req = 0;
            end
        end
        i_req = 0;
        chk("wrap_count", k, 3);
        @(negedge clk);

        // reset during ISSUE of a store drops it
        d_req = 1; d_we = 1; d_addr = 13'h0100; d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstw_issue_we", 32'(mem_we), 1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_we_drop", 32'(mem_we), 0);
        chk("rstw_busy", 32'(busy), 0);
        d_req = 0; d_we = 0;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d_ack) n++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d_ack) n++;
        end
        chk("rstw_noack", n, 0);
        run(1, 0, 13'h0100, 32'h0, 3, 32'h0, "rstw_load");
        chk("rstw_mem", mem[13'h0100], 32'h0);

        // both requesting continuously right after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_req = 1; i_addr = 13'h0010;
        d_req = 1; d_we = 0; d_addr = 13'h0020;
        seq = "";
        for (int c = 1; c <= 40 && seq.len() < 4; c++) begin
            @(negedge clk);
            if (d_ack) seq = {seq, "D"};
            if (i_ack) seq = {seq, "I"};
            if (d_ack || i_ack) chk($sformatf("cont%0d_cyc", seq.len()), c, 4 * seq.len() - 1);
        end
        i_req = 0; d_req = 0;
`ifdef ARB_RR_EN
        exp_seq = "DIDI";
`else
        exp_seq = "DDDD";
`endif
        n_checks++;
        assert (seq == exp_seq) else begin
            n_fail++;
            $error("FAIL cont_order: observed %s expected %s", seq, exp_seq);
        end
        chk("cont_drd", d_rdata, 32'h22222222);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a CPU instruction-fetch port and a data load/store port onto the single-port 8K x 32 unified instruction/data memory.
- Sits directly upstream of that memory and drives its write-enable, address and write-data inputs.
- Registers every memory-side output and accounts for the memory's one-cycle synchronous read latency.
- Returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
ADDR_W, 13, word address width; must match the memory depth (8192 words)
DATA_W, 32, data word width

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
i_req  in  1  instruction fetch request; held until i_ack
i_addr  in  ADDR_W  fetch word address; stable while i_req is high
i_rdata  out  DATA_W  fetched word; valid while i_ack is high, then held
i_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data access request; held until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req is high
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load result; valid while d_ack is high, then held
d_ack  out  1  one-cycle data completion pulse
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_din  out  DATA_W  memory write data, registered
mem_dout  in  DATA_W  memory read data; valid one edge after a read address is presented with mem_we = 0
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE; mem_we, mem_addr, mem_din, i_rdata, d_rdata, i_ack, d_ack = 0; grant register = instruction.
  - Reset mid-transaction abandons the access with no ack. A store whose mem_we was already registered but not yet clocked into memory is dropped, because mem_we clears asynchronously.
- States:
  - IDLE: sample requests.
    - If d_req = 1: grant data.
    - Else if i_req = 1: grant instruction.
    - On grant: register mem_addr (and mem_din, mem_we = d_we for data; mem_we = 0 for fetch); go to ISSUE.
    - With no request, mem_we stays 0 and mem_addr holds its last value.
  - ISSUE: memory samples the registered signals at the end of this cycle. Clear mem_we at the closing edge.
    - Write: go to ACK.
    - Read: go to RD_WAIT.
  - RD_WAIT: memory output is now valid. At the closing edge, capture mem_dout into the granted port's rdata register; go to ACK.
  - ACK: the granted port's ack = 1 for exactly this cycle, then IDLE. No requests are sampled in ACK.
- Latency, counted from the IDLE sampling edge:
  - Read: ack high in the 3rd cycle after that edge.
  - Write: ack high in the 2nd cycle after that edge.
- Throughput:
  - One transaction per 3 cycles (write) or 4 cycles (read).
  - A requester that keeps req high after its ack starts a new transaction at the following IDLE.
- Write safety: mem_we is 1 only during ISSUE of a store; it is never high in IDLE, RD_WAIT or ACK.
- Simultaneous requests (fixed priority): data wins; the fetch waits in IDLE until the data ack completes.
- Held outputs: i_rdata and d_rdata hold their value until the same port's next read capture. A store never alters d_rdata.
- Address: passes through unmodified. Wrap-around at 8191 is the requester's concern; no range check is performed.
- Requester rule: req, address, we and wdata must be stable from assertion until ack. Changes during a transaction are ignored once they have been latched.

Optional Feature:
- ARB_RR_EN defined:
  - When both ports request in IDLE, grant the port not granted last (round-robin). The grant register records the last winner, which is instruction after reset.
  - A lone request is always granted.
- ARB_RR_EN undefined: fixed data-over-instruction priority as described above. The grant register is unused.

Test Plan:
- Reset, then store d_addr = 0x0005, d_wdata = 0xDEADBEEF -> mem_we = 1 for exactly one cycle with mem_addr = 0x0005; d_ack in cycle 2; busy high for 2 cycles.
- Load d_addr = 0x0005 after that store -> d_ack in cycle 3 with d_rdata = 0xDEADBEEF; mem_we stays 0 throughout.
- i_req and d_req rise together (fixed priority), preloaded mem[0x0010] = 0x11111111 and mem[0x0020] = 0x22222222, i_addr = 0x0010, d_addr = 0x0020 -> d_ack first with 0x22222222, then i_ack with 0x11111111; d_rdata stays unchanged after the fetch.
- i_req held high continuously over addresses 0x1FFE, 0x1FFF, 0x0000 -> i_ack every 4 cycles with the matching words; no gaps beyond the IDLE cycle.
- Assert rst during ISSUE of a store to 0x0100 (old value 0x0) -> mem_we drops immediately; no d_ack; a later load of 0x0100 returns 0x0.
- With ARB_RR_EN, both ports requesting continuously -> acks alternate instruction/data, starting with data after reset.
